// File: rtl/mc_modport.sv
// AXI slave port backed by a word-addressed storage array; one burst in flight, AW has priority over AR.
// Latency: A-handshake -> wready/rvalid next cycle, last W -> bvalid next cycle; B/R outputs hold while bready/rready are low.
module mc_modport #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_LEN   = 4,
    parameter int MEM_AW     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [ADDR_LEN-1:0]     awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [ADDR_LEN-1:0]     arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [ID_WIDTH-1:0]     wid,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFF = $clog2(NB);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WDATA = 2'd1;
    localparam logic [1:0] S_WRESP = 2'd2;
    localparam logic [1:0] S_RDATA = 2'd3;

    localparam logic [ADDR_LEN-1:0] CNT_ONE = 1;
    localparam logic [MEM_AW-1:0]   IDX_ONE = 1;

    logic [1:0]            state;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_LEN-1:0]   len_q;
    logic [ADDR_LEN-1:0]   cnt;
    logic                  fixed_q;
    logic                  err;
    logic [MEM_AW-1:0]     idx;
    logic [MEM_AW-1:0]     idx_next;
    logic                  last_beat;
    logic                  w_hs;

    logic [DATA_WIDTH-1:0] mem [0:(1<<MEM_AW)-1];

    // Size fields and address bits above the word index do not affect behaviour.
    logic unused_bits;
    assign unused_bits = ^{awsize, arsize, awaddr, araddr};

    // Handshake outputs are gated by rst_n so everything is quiet while reset is held.
    assign awready   = rst_n && (state == S_IDLE);
    assign arready   = rst_n && (state == S_IDLE) && !awvalid;
    assign wready    = rst_n && (state == S_WDATA);
    assign bvalid    = rst_n && (state == S_WRESP);
    assign rvalid    = rst_n && (state == S_RDATA);

    assign last_beat = (cnt == len_q);
    assign idx_next  = fixed_q ? idx : idx + IDX_ONE;
    assign w_hs      = wvalid && wready;

    assign bid       = id_q;
    assign bresp     = {err, 1'b0};
    assign rid       = id_q;
    assign rresp     = 2'b00;
    assign rlast     = rvalid && last_beat;
    assign rdata     = mem[idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            id_q    <= '0;
            len_q   <= '0;
            cnt     <= '0;
            fixed_q <= 1'b0;
            err     <= 1'b0;
            idx     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (awvalid) begin
                        id_q    <= awid;
                        len_q   <= awlen;
                        fixed_q <= (awburst == 2'b00);
                        idx     <= awaddr[OFF +: MEM_AW];
                        cnt     <= '0;
                        state   <= S_WDATA;
                    end else if (arvalid) begin
                        id_q    <= arid;
                        len_q   <= arlen;
                        fixed_q <= (arburst == 2'b00);
                        idx     <= araddr[OFF +: MEM_AW];
                        cnt     <= '0;
                        state   <= S_RDATA;
                    end
                end
                S_WDATA: begin
                    if (wvalid) begin
                        // The burst length, not wlast, decides where the burst ends.
                        if ((wid != id_q) || (wlast != last_beat)) begin
                            err <= 1'b1;
                        end
                        idx <= idx_next;
                        cnt <= cnt + CNT_ONE;
                        if (last_beat) begin
                            state <= S_WRESP;
                        end
                    end
                end
                S_WRESP: begin
                    if (bready) begin
                        err   <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_RDATA: begin
                    if (rready) begin
                        idx <= idx_next;
                        cnt <= cnt + CNT_ONE;
                        if (last_beat) begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb[b]) begin
                    mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mc_modport.sv
// Directed plus randomized bursts against a byte-level memory model of the port.
module tb_mc_modport;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         awvalid, awready, arvalid, arready;
    logic [3:0]   awid, arid, wid, bid, rid;
    logic [31:0]  awaddr, araddr;
    logic [3:0]   awlen, arlen;
    logic [2:0]   awsize, arsize;
    logic [1:0]   awburst, arburst, bresp, rresp;
    logic         wvalid, wready, wlast, bvalid, bready, rvalid, rready, rlast;
    logic [127:0] wdata, rdata;
    logic [15:0]  wstrb;

    always #5 clk = ~clk;

    mc_modport dut (
        .clk(clk), .rst_n(rst_n),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata),
        .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
        .rresp(rresp), .rlast(rlast)
    );

    logic [127:0] ref_mem   [256];
    logic [127:0] beat_dat  [16];
    logic [15:0]  beat_strb [16];
    logic         beat_last [16];
    logic [3:0]   beat_wid  [16];

    int checks = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr / 32'd16) % 32'd256);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic fill_beats(input int len, input logic [3:0] id, input logic full_strb);
        for (int k = 0; k <= len; k++) begin
            beat_dat[k]  = rand128();
            beat_strb[k] = full_strb ? 16'hFFFF : 16'($urandom);
            beat_last[k] = (k == len);
            beat_wid[k]  = id;
        end
    endtask

    task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr, input int len, input logic [1:0] burst);
        awvalid = 1'b1; awid = id; awaddr = addr; awlen = 4'(len); awburst = burst; awsize = 3'd4;
        for (int t = 0; t < 50 && !awready; t++) tick();
        chk("aw_accept", awready, 1);
        tick();
        awvalid = 1'b0;
        chk("wready_latency", wready, 1);
    endtask

    task automatic w_phase(input logic [3:0] id, input logic [31:0] addr, input int len, input logic [1:0] burst);
        logic       exp_err;
        logic [1:0] exp_resp;
        int         w0, w;
        exp_err = 1'b0;
        w0 = word_of(addr);
        for (int k = 0; k <= len; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                tick();
            end
            wvalid = 1'b1; wid = beat_wid[k]; wdata = beat_dat[k];
            wstrb = beat_strb[k]; wlast = beat_last[k];
            for (int t = 0; t < 50 && !wready; t++) tick();
            chk("w_accept", wready, 1);
            tick();
            w = (burst == 2'd0) ? w0 : (w0 + k) % 256;
            for (int b = 0; b < 16; b++)
                if (beat_strb[k][b]) ref_mem[w][b*8 +: 8] = beat_dat[k][b*8 +: 8];
            if (beat_wid[k] != id || beat_last[k] != (k == len)) exp_err = 1'b1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        exp_resp = exp_err ? 2'b10 : 2'b00;
        chk("bvalid_latency", bvalid, 1);
        chk("bid", bid, id);
        chk("bresp", bresp, exp_resp);
        repeat ($urandom_range(0, 2)) begin
            tick();
            chk("bvalid_hold", bvalid, 1);
            chk("bresp_hold", bresp, exp_resp);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("b_done", bvalid, 0);
        chk("awready_after_b", awready, 1);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len, input logic [1:0] burst);
        aw_phase(id, addr, len, burst);
        w_phase(id, addr, len, burst);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input int stall_at, input logic rnd_stall);
        int           w0, w, s;
        logic [127:0] exp;
        arvalid = 1'b1; arid = id; araddr = addr; arlen = 4'(len); arburst = burst; arsize = 3'd4;
        for (int t = 0; t < 50 && !arready; t++) tick();
        chk("ar_accept", arready, 1);
        tick();
        arvalid = 1'b0;
        chk("rvalid_latency", rvalid, 1);
        w0 = word_of(addr);
        for (int k = 0; k <= len; k++) begin
            w   = (burst == 2'd0) ? w0 : (w0 + k) % 256;
            exp = ref_mem[w];
            s   = (k == stall_at) ? 3 : (rnd_stall ? $urandom_range(0, 2) : 0);
            rready = 1'b0;
            repeat (s) begin
                chk("rdata_stall", rdata, exp);
                chk("rlast_stall", rlast, k == len);
                tick();
            end
            rready = 1'b1;
            chk("rvalid", rvalid, 1);
            chk("rdata", rdata, exp);
            chk("rlast", rlast, k == len);
            chk("rid", rid, id);
            chk("rresp", rresp, 0);
            tick();
        end
        rready = 1'b0;
        chk("r_done", rvalid, 0);
        chk("awready_after_r", awready, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
        arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
        wvalid = 0; wid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0; rready = 0;
        tick();
        tick();
        chk("rst_awready", awready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bid", bid, 0);
        chk("rst_rid", rid, 0);
        chk("rst_bresp", bresp, 0);
        rst_n = 1'b1;
        #1;
        chk("idle_awready", awready, 1);
        chk("idle_arready", arready, 1);
        chk("idle_wready", wready, 0);

        // Give every storage word a known value.
        for (int i = 0; i < 16; i++) begin
            fill_beats(15, 4'(i), 1'b1);
            do_write(4'(i), 32'(i * 256), 15, 2'd1);
        end

        // Single-beat write/read.
        fill_beats(0, 4'd3, 1'b1);
        beat_dat[0] = {16{8'hA5}};
        do_write(4'd3, 32'h40, 0, 2'd1);
        do_read(4'd3, 32'h40, 0, 2'd1, -1, 1'b0);

        // INCR burst of four.
        fill_beats(3, 4'd1, 1'b1);
        for (int k = 0; k < 4; k++) beat_dat[k] = 128'(k + 1);
        do_write(4'd1, 32'h100, 3, 2'd1);
        do_read(4'd1, 32'h100, 3, 2'd1, -1, 1'b0);

        // Partial strobe over a word of ones.
        fill_beats(0, 4'd2, 1'b1);
        beat_dat[0] = '1;
        do_write(4'd2, 32'h500, 0, 2'd1);
        fill_beats(0, 4'd2, 1'b0);
        beat_dat[0] = '0;
        beat_strb[0] = 16'h0001;
        do_write(4'd2, 32'h500, 0, 2'd1);
        do_read(4'd2, 32'h500, 0, 2'd1, -1, 1'b0);

        // AW and AR together: AW wins, AR follows the B handshake.
        arvalid = 1'b1; arid = 4'd7; araddr = 32'h100; arlen = 4'd3; arburst = 2'd1;
        awvalid = 1'b1; awid = 4'd2; awaddr = 32'h600; awlen = 4'd0; awburst = 2'd1;
        #1;
        chk("both_awready", awready, 1);
        chk("both_arready", arready, 0);
        fill_beats(0, 4'd2, 1'b1);
        aw_phase(4'd2, 32'h600, 0, 2'd1);
        chk("arready_in_wdata", arready, 0);
        w_phase(4'd2, 32'h600, 0, 2'd1);
        chk("arready_after_b", arready, 1);
        do_read(4'd7, 32'h100, 3, 2'd1, 1, 1'b0);

        // Early wlast flags the burst but all four beats still transfer.
        fill_beats(3, 4'd9, 1'b1);
        beat_last[1] = 1'b1;
        beat_last[3] = 1'b0;
        do_write(4'd9, 32'h700, 3, 2'd1);
        do_read(4'd9, 32'h700, 3, 2'd1, 2, 1'b0);

        // Reset in the middle of a write burst.
        fill_beats(3, 4'd5, 1'b1);
        aw_phase(4'd5, 32'h200, 3, 2'd1);
        wvalid = 1'b1; wid = 4'd5; wdata = beat_dat[0]; wstrb = 16'hFFFF; wlast = 1'b0;
        tick();
        ref_mem[32] = beat_dat[0];
        wvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_wready", wready, 0);
        chk("mrst_awready", awready, 0);
        chk("mrst_arready", arready, 0);
        chk("mrst_bvalid", bvalid, 0);
        chk("mrst_rvalid", rvalid, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_awready", awready, 1);
        chk("post_rst_wready", wready, 0);
        chk("post_rst_bvalid", bvalid, 0);
        fill_beats(1, 4'd6, 1'b1);
        do_write(4'd6, 32'h300, 1, 2'd1);
        do_read(4'd6, 32'h300, 1, 2'd1, -1, 1'b0);
        do_read(4'd4, 32'h200, 3, 2'd1, -1, 1'b0);

        // Randomized traffic: any burst type, wrap-around, upper address bits, protocol errors.
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  id;
            logic [31:0] addr;
            int          len;
            logic [1:0]  burst;
            id    = 4'($urandom);
            addr  = $urandom;
            len   = $urandom_range(0, 15);
            burst = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 0) begin
                fill_beats(len, id, 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 5) == 0) beat_last[$urandom_range(0, len)] ^= 1'b1;
                if ($urandom_range(0, 5) == 0) beat_wid[$urandom_range(0, len)] = ~id;
                do_write(id, addr, len, burst);
            end else begin
                do_read(id, addr, len, burst, -1, 1'b1);
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
